// File: rtl/out_rdr_pkg.sv
// Shared state encoding and elaboration helpers for the output-register reader.
package out_rdr_pkg;

   typedef enum logic {
      IDLE   = 1'b0,
      STREAM = 1'b1
   } rdr_state_t;

   // Constant function so parameter consistency can be checked at elaboration.
   function automatic int out_rdr_clog2(input int value);
      int result;
      int v;
      result = 0;
      v      = value - 1;
      while (v > 0) begin
         result = result + 1;
         v      = v >> 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/out_rdr_snapshot_buf.sv
// Snapshot register array: parallel load of all lanes, cleared by reset, read through an index mux.
// Load takes effect on the next clock; the read path is purely combinational from the registers.
module out_rdr_snapshot_buf
   import out_rdr_pkg::*;
#(
   parameter int REG_DATA_WIDTH = 16,
   parameter int NUM_LANES      = 8,
   parameter int LANE_IDX_WIDTH = 3
)(
   input  logic                                clk,
   input  logic                                reset,
   input  logic                                load,
   input  logic [NUM_LANES*REG_DATA_WIDTH-1:0] wr_data,
   input  logic [LANE_IDX_WIDTH-1:0]           rd_index,
   output logic [REG_DATA_WIDTH-1:0]           rd_data
);

   logic [NUM_LANES-1:0][REG_DATA_WIDTH-1:0] lane_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         lane_q <= '0;
      end else if (load) begin
         lane_q <= wr_data;
      end
   end

   assign rd_data = lane_q[rd_index];

endmodule

// File: rtl/out_reg_reader.sv
// Snapshots NUM_LANES result words on Capture and drains them lane 0 first; Valid follows Capture by one cycle.
// Outputs hold while Ready is low; a Capture that cannot be taken is dropped and flagged in Overrun.
module out_reg_reader
   import out_rdr_pkg::*;
#(
   parameter int REG_DATA_WIDTH = 16,
   parameter int NUM_LANES      = 8,
   parameter int LANE_IDX_WIDTH = 3
)(
   input  logic                                OUT_RDR_Clk,
   input  logic                                OUT_RDR_Reset,
   input  logic                                OUT_RDR_Capture,
   input  logic [NUM_LANES*REG_DATA_WIDTH-1:0] OUT_RDR_Lanes_Data,
   input  logic                                OUT_RDR_Out_Ready,
   input  logic                                OUT_RDR_Clear_Overrun,
   output logic                                OUT_RDR_Out_Valid,
   output logic [REG_DATA_WIDTH-1:0]           OUT_RDR_Out_Data,
   output logic [LANE_IDX_WIDTH-1:0]           OUT_RDR_Out_Index,
   output logic                                OUT_RDR_Out_Last,
   output logic                                OUT_RDR_Busy,
   output logic                                OUT_RDR_Overrun
);

   if ((LANE_IDX_WIDTH != out_rdr_clog2(NUM_LANES)) || (NUM_LANES < 2)) begin : g_bad_params
      $error("out_reg_reader: LANE_IDX_WIDTH must equal clog2(NUM_LANES) and NUM_LANES must be >= 2");
   end

   localparam logic [LANE_IDX_WIDTH-1:0] LAST_IDX = LANE_IDX_WIDTH'(NUM_LANES - 1);

   rdr_state_t                state_q, state_d;
   logic [LANE_IDX_WIDTH-1:0] index_q, index_d;
   logic                      overrun_q, overrun_d;
   logic                      overrun_set;
   logic                      snap_load;
   logic                      at_last;

   assign at_last = (index_q == LAST_IDX);

   always_ff @(posedge OUT_RDR_Clk) begin
      if (OUT_RDR_Reset) begin
         state_q   <= IDLE;
         index_q   <= '0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         index_q   <= index_d;
         overrun_q <= overrun_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      index_d     = index_q;
      snap_load   = 1'b0;
      overrun_set = 1'b0;
      case (state_q)
         IDLE: begin
            if (OUT_RDR_Capture) begin
               snap_load = 1'b1;
               index_d   = '0;
               state_d   = STREAM;
            end
         end
         STREAM: begin
            if (OUT_RDR_Out_Ready && at_last) begin
               // Capture on the final transfer starts the next set with no bubble.
               if (OUT_RDR_Capture) begin
                  snap_load = 1'b1;
                  index_d   = '0;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               if (OUT_RDR_Out_Ready) begin
                  index_d = index_q + LANE_IDX_WIDTH'(1);
               end
               overrun_set = OUT_RDR_Capture;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      // Set has priority over clear.
      overrun_d = overrun_set | (overrun_q & ~OUT_RDR_Clear_Overrun);
   end

   out_rdr_snapshot_buf #(
      .REG_DATA_WIDTH (REG_DATA_WIDTH),
      .NUM_LANES      (NUM_LANES),
      .LANE_IDX_WIDTH (LANE_IDX_WIDTH)
   ) u_snapshot_buf (
      .clk      (OUT_RDR_Clk),
      .reset    (OUT_RDR_Reset),
      .load     (snap_load),
      .wr_data  (OUT_RDR_Lanes_Data),
      .rd_index (index_q),
      .rd_data  (OUT_RDR_Out_Data)
   );

   assign OUT_RDR_Out_Valid = (state_q == STREAM);
   assign OUT_RDR_Busy      = (state_q == STREAM);
   assign OUT_RDR_Out_Index = index_q;
   assign OUT_RDR_Out_Last  = (state_q == STREAM) && at_last;
   assign OUT_RDR_Overrun   = overrun_q;

endmodule

// File: tb/tb_out_reg_reader.sv
// Bench for out_reg_reader: queue-of-beats reference model checked every cycle, plus directed literal checks.
module tb_out_reg_reader;

   localparam int W  = 16;
   localparam int N  = 8;
   localparam int IW = 3;

   logic          clk = 1'b0;
   logic          rst;
   logic          cap;
   logic          rdy;
   logic          clr;
   logic [N*W-1:0] lanes;

   logic          out_vld;
   logic [W-1:0]  out_dat;
   logic [IW-1:0] out_idx;
   logic          out_last;
   logic          busy;
   logic          ovr;

   int n_tests = 0;
   int n_fail  = 0;

   out_reg_reader #(
      .REG_DATA_WIDTH (W),
      .NUM_LANES      (N),
      .LANE_IDX_WIDTH (IW)
   ) dut (
      .OUT_RDR_Clk           (clk),
      .OUT_RDR_Reset         (rst),
      .OUT_RDR_Capture       (cap),
      .OUT_RDR_Lanes_Data    (lanes),
      .OUT_RDR_Out_Ready     (rdy),
      .OUT_RDR_Clear_Overrun (clr),
      .OUT_RDR_Out_Valid     (out_vld),
      .OUT_RDR_Out_Data      (out_dat),
      .OUT_RDR_Out_Index     (out_idx),
      .OUT_RDR_Out_Last      (out_last),
      .OUT_RDR_Busy          (busy),
      .OUT_RDR_Overrun       (ovr)
   );

   always #5 clk = ~clk;

   function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endfunction

   // Reference: the beats still owed to the host, front = current beat.
   logic [W-1:0] exp_q[$];
   bit           exp_ovr;
   int           m_sz;
   bit           m_pop;
   bit           m_take;

   always @(posedge clk) begin
      if (rst) begin
         exp_q.delete();
         exp_ovr = 1'b0;
      end else begin
         m_sz   = exp_q.size();
         m_pop  = (m_sz != 0) && rdy;
         m_take = cap && ((m_sz == 0) || ((m_sz == 1) && m_pop));
         if (m_pop) void'(exp_q.pop_front());
         if (m_take) for (int i = 0; i < N; i++) exp_q.push_back(lanes[i*W +: W]);
         exp_ovr = (cap && !m_take) || (exp_ovr && !clr);
      end
   end

   always @(negedge clk) begin
      chk("valid", {31'd0, out_vld}, {31'd0, exp_q.size() != 0});
      chk("busy", {31'd0, busy}, {31'd0, exp_q.size() != 0});
      chk("overrun", {31'd0, ovr}, {31'd0, exp_ovr});
      if (exp_q.size() != 0) begin
         chk("data", {16'd0, out_dat}, {16'd0, exp_q[0]});
         chk("index", {29'd0, out_idx}, N - exp_q.size());
         chk("last", {31'd0, out_last}, {31'd0, exp_q.size() == 1});
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [N*W-1:0] rand_lanes();
      logic [N*W-1:0] v;
      for (int i = 0; i < N; i++) v[i*W +: W] = W'($urandom);
      return v;
   endfunction

   logic [N*W-1:0] lanes_b;
   logic           pat [4];

   initial begin
      rst = 1'b1; cap = 1'b0; rdy = 1'b0; clr = 1'b0; lanes = '0;
      pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
      tick();
      @(negedge clk);
      chk("rst_valid", {31'd0, out_vld}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_overrun", {31'd0, ovr}, 32'd0);
      chk("rst_data", {16'd0, out_dat}, 32'd0);
      tick();
      rst = 1'b0;

      // Basic drain, lane i = i.
      for (int i = 0; i < N; i++) lanes[i*W +: W] = W'(i);
      cap = 1'b1; tick(); cap = 1'b0; rdy = 1'b1;
      for (int b = 0; b < N; b++) begin
         @(negedge clk);
         chk("basic_valid", {31'd0, out_vld}, 32'd1);
         chk("basic_data", {16'd0, out_dat}, b);
         chk("basic_index", {29'd0, out_idx}, b);
         chk("basic_last", {31'd0, out_last}, (b == N - 1) ? 32'd1 : 32'd0);
         tick();
      end
      @(negedge clk);
      chk("basic_busy_drop", {31'd0, busy}, 32'd0);

      // Backpressure with lanes changing after capture.
      lanes = rand_lanes();
      lanes[15:0] = 16'hFFFF;
      lanes[31:16] = 16'h8000;
      rdy = 1'b0; cap = 1'b1; tick(); cap = 1'b0; lanes = rand_lanes();
      @(negedge clk);
      chk("bp_first", {16'd0, out_dat}, 32'h0000FFFF);
      rdy = 1'b1; tick(); rdy = 1'b0; lanes = rand_lanes();
      @(negedge clk);
      chk("bp_second", {16'd0, out_dat}, 32'h00008000);
      chk("bp_second_idx", {29'd0, out_idx}, 32'd1);
      for (int k = 0; k < 40; k++) begin
         rdy = pat[k % 4];
         lanes = rand_lanes();
         tick();
      end
      rdy = 1'b1;

      // Overrun: capture at index 2, then clear, then clear+capture at index 4.
      lanes = rand_lanes();
      cap = 1'b1; tick(); cap = 1'b0;
      tick(); tick();
      lanes = rand_lanes(); cap = 1'b1; tick(); cap = 1'b0;
      @(negedge clk);
      chk("ovr_set", {31'd0, ovr}, 32'd1);
      chk("ovr_idx", {29'd0, out_idx}, 32'd3);
      repeat (6) tick();
      clr = 1'b1; tick(); clr = 1'b0;
      @(negedge clk);
      chk("ovr_clear", {31'd0, ovr}, 32'd0);
      lanes = rand_lanes();
      cap = 1'b1; tick(); cap = 1'b0;
      repeat (4) tick();
      cap = 1'b1; clr = 1'b1; tick(); cap = 1'b0; clr = 1'b0;
      @(negedge clk);
      chk("ovr_set_wins", {31'd0, ovr}, 32'd1);
      repeat (5) tick();
      clr = 1'b1; tick(); clr = 1'b0;

      // Reset mid-stream at index 3 with Overrun set.
      lanes = rand_lanes();
      cap = 1'b1; tick(); cap = 1'b0;
      tick();
      cap = 1'b1; tick(); cap = 1'b0;
      tick();
      @(negedge clk);
      chk("mid_idx3", {29'd0, out_idx}, 32'd3);
      rst = 1'b1; tick(); rst = 1'b0;
      @(negedge clk);
      chk("mid_rst_valid", {31'd0, out_vld}, 32'd0);
      chk("mid_rst_busy", {31'd0, busy}, 32'd0);
      chk("mid_rst_ovr", {31'd0, ovr}, 32'd0);
      chk("mid_rst_data", {16'd0, out_dat}, 32'd0);
      lanes = rand_lanes();
      cap = 1'b1; tick(); cap = 1'b0;
      @(negedge clk);
      chk("restart_idx", {29'd0, out_idx}, 32'd0);
      chk("restart_data", {16'd0, out_dat}, {16'd0, lanes[15:0]});
      repeat (9) tick();

      // Back-to-back capture on the final transfer.
      lanes = rand_lanes();
      cap = 1'b1; tick(); cap = 1'b0;
      repeat (7) tick();
      lanes_b = rand_lanes();
      lanes = lanes_b;
      cap = 1'b1; tick(); cap = 1'b0; lanes = rand_lanes();
      @(negedge clk);
      chk("b2b_idx", {29'd0, out_idx}, 32'd0);
      chk("b2b_data", {16'd0, out_dat}, {16'd0, lanes_b[15:0]});
      chk("b2b_busy", {31'd0, busy}, 32'd1);
      chk("b2b_ovr", {31'd0, ovr}, 32'd0);
      repeat (9) tick();

      // Randomized traffic.
      for (int c = 0; c < 3000; c++) begin
         rst   = ($urandom_range(0, 399) == 0);
         cap   = ($urandom_range(0, 7) == 0);
         rdy   = ($urandom_range(0, 9) < 7);
         clr   = ($urandom_range(0, 15) == 0);
         lanes = rand_lanes();
         tick();
      end
      rst = 1'b0; cap = 1'b0; clr = 1'b0;
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
